mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Responder end of the byte-wide memory bus that the cache drives. Each cycle it
//  accepts one byte access (addr_in, r_nw_in, data_in) and returns read data one
//  cycle later. Addresses with addr_in[17]=0 map to on-chip byte RAM; addr_in[17]=1
//  maps to IO registers. The IO registers front a UART through TX/RX FIFOs.
// PARAMETERS
//  RAM_AW        17  RAM byte-address width (RAM depth = 2**RAM_AW bytes)
//  FIFO_AW       4   log2 of TX and RX FIFO depth (16 entries each)
// PORTS
//  clk            in   1   clock, posedge
//  rst_n          in   1   async active-low reset
//  addr_in        in   32  byte address of access (idle initiator drives 0, read)
//  r_nw_in        in   1   1 = read, 0 = write
//  data_in        in   8   write byte
//  data_out       out  8   read byte; valid the cycle after the read is sampled
//  io_buffer_full out  1   TX FIFO holds >= depth-2 entries; initiator stops IO writes
//  uart_rx_valid  in   1   RX byte strobe from UART
//  uart_rx_data   in   8   RX byte
//  uart_tx_valid  out  1   TX FIFO head present
//  uart_tx_data   out  8   TX FIFO head byte
//  uart_tx_ready  in   1   UART accepts head this cycle
//  sim_halt       out  1   sticky halt flag
//  drop_cnt       out  8   saturating count of writes lost on full TX FIFO
// BEHAVIOUR
//  Reset (rst_n low, async): data_out=0, uart_tx_valid=0, sim_halt=0, drop_cnt=0,
//   both FIFOs emptied (pointers and counts 0), io_buffer_full=0. RAM is not cleared.
//   Reset mid-access discards the access; pending TX bytes are lost.
//  Every posedge samples one access; there is no stall. Back-to-back accesses are legal.
//  RAM, addr_in[17]=0: index addr_in[RAM_AW-1:0]. Write: mem<=data_in. Read: data_out<=mem
//   at the next edge (1-cycle latency). Read-during-write to the same byte returns old data.
//  IO, addr_in[17]=1; register select addr_in[2:0]; other address bits ignored:
//   0: read pops RX FIFO head into data_out; if RX is empty, returns 8'h00, no pop.
//      write pushes data_in to TX FIFO; if TX is full, drops the byte, drop_cnt++ (sat 255).
//   4: read returns {6'b0, tx_full, rx_nonempty}; write sets sim_halt=1 (sticky until reset).
//   any other select: read returns 8'h00; write is ignored.
//  Writes drive data_out to 8'h00 on the next cycle.
//  RX FIFO: push on uart_rx_valid. If full, the byte is discarded (no counter).
//   Simultaneous push and pop on a non-empty FIFO: both happen and the count is unchanged.
//   Simultaneous push and pop on an empty FIFO: the read returns 00 and the byte is stored.
//  TX FIFO: uart_tx_valid = !empty; uart_tx_data = head. Pop when valid && uart_tx_ready.
//   A push to a full FIFO in the same cycle as a pop is accepted (count stays at depth).
//  io_buffer_full: registered, set when TX count >= 2**FIFO_AW-2. This covers the
//   2-cycle initiator reaction window.
//  Pointers are FIFO_AW bits wide and wrap modulo depth. Counts are FIFO_AW+1 bits wide.
//  Status and flags reflect state before the current edge's push and pop.
// TESTING
//  1 RAM: write 0x12 to 0x00100, then read 0x00100 the next cycle -> data_out=0x12 one
//    cycle after the read; a read of 0x1FFFF after writing 0xAB there -> 0xAB.
//  2 TX: write 'H','i' to 0x30000 with uart_tx_ready=1 -> uart_tx_valid pulses with
//    0x48 then 0x69 in order; status read (0x30004) then shows bit1=0.
//  3 TX full: hold uart_tx_ready=0 and write 18 bytes -> io_buffer_full=1 after
//    14 entries, 16 bytes stored, drop_cnt=2; release ready -> the first 16 bytes drain in order.
//  4 RX: pulse uart_rx_valid with 0x5A, then read 0x30004 -> 0x01; read 0x30000 -> 0x5A;
//    read 0x30000 again -> 0x00.
//  5 Halt: write any byte to 0x30004 -> sim_halt=1 next cycle; it stays set until
//    rst_n goes low.
//  6 Reset mid-stream: with 5 TX bytes queued, pulse rst_n low for a sub-cycle ->
//    uart_tx_valid=0 and data_out=0 immediately; RAM contents are retained.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the cache (initiator) and the responder.
// The initiator drives one access per cycle; read data returns a cycle later.
interface mem_io_if;
   logic [31:0] addr_in;
   logic        r_nw_in;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        io_buffer_full;

   modport master (
      output addr_in, r_nw_in, data_in,
      input  data_out, io_buffer_full
   );

   modport slave (
      input  addr_in, r_nw_in, data_in,
      output data_out, io_buffer_full
   );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the cache's byte bus: on-chip byte RAM below addr[17], and a
// small IO register block above it that fronts a UART through TX/RX FIFOs.
// One access is sampled every edge with no stall; read data lands in data_out
// on the following cycle.
module mem_io_responder #(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_io_if.slave    bus,
   input  logic       uart_rx_valid,
   input  logic [7:0] uart_rx_data,
   output logic       uart_tx_valid,
   output logic [7:0] uart_tx_data,
   input  logic       uart_tx_ready,
   output logic       sim_halt,
   output logic [7:0] drop_cnt
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_HIGH = (FIFO_AW + 1)'(DEPTH - 2);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW - 1){1'b0}}, 1'b1};
   localparam logic [2:0]         SEL_DATA = 3'd0;
   localparam logic [2:0]         SEL_STAT = 3'd4;

   // Which source drives data_out this cycle; ZERO covers writes and reset.
   typedef enum logic [1:0] {
      RSP_ZERO,
      RSP_RAM,
      RSP_REG
   } rsp_e;

   // Storage (never reset)
   logic [7:0] mem    [2**RAM_AW];
   logic [7:0] rx_mem [DEPTH];
   logic [7:0] tx_mem [DEPTH];

   // Response path
   rsp_e       rsp_sel;
   logic [7:0] ram_q;
   logic [7:0] reg_q;

   // FIFO control
   logic [FIFO_AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic [FIFO_AW:0]   rx_cnt, tx_cnt, tx_cnt_nxt;

   // Access decode
   logic              is_io;
   logic [2:0]        io_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_we, ram_rd;
   logic              rd_rx, rd_stat, wr_tx, wr_halt;
   logic              rx_empty, rx_full, tx_empty, tx_full;
   logic              rx_push, rx_pop, tx_push, tx_pop, tx_drop;
   logic [7:0]        rx_head, status;
   logic              unused_addr;

   // High address bits play no part in RAM or IO decode.
   assign unused_addr = ^bus.addr_in[31:18];

   // Decode the sampled access and derive FIFO push/pop from pre-edge state
   always_comb begin
      is_io    = bus.addr_in[17];
      io_sel   = bus.addr_in[2:0];
      ram_idx  = bus.addr_in[RAM_AW-1:0];
      ram_we   = !is_io && !bus.r_nw_in;
      ram_rd   = !is_io &&  bus.r_nw_in;
      rd_rx    = is_io &&  bus.r_nw_in && (io_sel == SEL_DATA);
      wr_tx    = is_io && !bus.r_nw_in && (io_sel == SEL_DATA);
      rd_stat  = is_io &&  bus.r_nw_in && (io_sel == SEL_STAT);
      wr_halt  = is_io && !bus.r_nw_in && (io_sel == SEL_STAT);

      rx_empty = (rx_cnt == '0);
      rx_full  = (rx_cnt == CNT_FULL);
      tx_empty = (tx_cnt == '0);
      tx_full  = (tx_cnt == CNT_FULL);

      rx_pop   = rd_rx && !rx_empty;
      rx_push  = uart_rx_valid && !rx_full;
      tx_pop   = !tx_empty && uart_tx_ready;
      // A full TX FIFO still takes the byte when its head leaves this edge.
      tx_push  = wr_tx && (!tx_full || tx_pop);
      tx_drop  = wr_tx && !tx_push;

      tx_cnt_nxt = tx_cnt + (FIFO_AW + 1)'(tx_push) - (FIFO_AW + 1)'(tx_pop);

      rx_head  = rx_mem[rx_rp];
      status   = {6'b0, tx_full, !rx_empty};
   end

   // RAM write port plus unconditional registered read (old data on collision)
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_idx] <= bus.data_in;
      end
      ram_q <= mem[ram_idx];
   end

   // IO read value captured for the next cycle
   always_ff @(posedge clk) begin
      if (rd_rx) begin
         reg_q <= rx_empty ? 8'h00 : rx_head;
      end else if (rd_stat) begin
         reg_q <= status;
      end else begin
         reg_q <= 8'h00;
      end
   end

   // Response source select; reset forces data_out to zero immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_sel <= RSP_ZERO;
      end else if (ram_rd) begin
         rsp_sel <= RSP_RAM;
      end else if (is_io && bus.r_nw_in) begin
         rsp_sel <= RSP_REG;
      end else begin
         rsp_sel <= RSP_ZERO;
      end
   end

   // Read data mux
   always_comb begin
      bus.data_out = 8'h00;
      case (rsp_sel)
         RSP_RAM: bus.data_out = ram_q;
         RSP_REG: bus.data_out = reg_q;
         default: bus.data_out = 8'h00;
      endcase
   end

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_mem[rx_wp] <= uart_rx_data;
      end
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) begin
            rx_wp <= rx_wp + PTR_ONE;
         end
         if (rx_pop) begin
            rx_rp <= rx_rp + PTR_ONE;
         end
         rx_cnt <= rx_cnt + (FIFO_AW + 1)'(rx_push) - (FIFO_AW + 1)'(rx_pop);
      end
   end

   // TX FIFO storage
   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem[tx_wp] <= bus.data_in;
      end
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) begin
            tx_wp <= tx_wp + PTR_ONE;
         end
         if (tx_pop) begin
            tx_rp <= tx_rp + PTR_ONE;
         end
         tx_cnt <= tx_cnt_nxt;
      end
   end

   assign uart_tx_valid = !tx_empty;
   assign uart_tx_data  = tx_mem[tx_rp];

   // Back-pressure flag, halt latch and saturating drop counter.
   // The flag rises two entries early so the initiator's two-cycle
   // reaction still lands inside the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.io_buffer_full <= 1'b0;
         sim_halt           <= 1'b0;
         drop_cnt           <= 8'h00;
      end else begin
         bus.io_buffer_full <= (tx_cnt_nxt >= CNT_HIGH);
         if (wr_halt) begin
            sim_halt <= 1'b1;
         end
         if (tx_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus randomized traffic,
// compared against a queue/array model of the responder's behaviour.
module tb_mem_io_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx_valid = 1'b0;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_tx_valid;
   logic [7:0] uart_tx_data;
   logic       uart_tx_ready = 1'b0;
   logic       sim_halt;
   logic [7:0] drop_cnt;

   mem_io_if bus ();

   mem_io_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_ready (uart_tx_ready),
      .sim_halt      (sim_halt),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   byte unsigned ram_m [int];
   byte unsigned tx_q [$];
   byte unsigned rx_q [$];
   byte unsigned m_tx_log [$];
   byte unsigned dut_tx_log [$];
   int           drop_m = 0;
   bit           halt_m = 0;
   logic [7:0]   exp_dout = 8'h00;
   bit           exp_known = 1;

   // Capture bytes the UART side actually accepts
   always @(negedge clk) begin
      if (rst_n && uart_tx_valid && uart_tx_ready) begin
         dut_tx_log.push_back(uart_tx_data);
      end
   end

   // Drive one access for one edge and advance the model accordingly
   task automatic step(input logic [31:0] a, input logic rnw, input logic [7:0] d,
                       input logic rxv, input logic [7:0] rxd, input logic txr);
      bit         tx_full_pre, rx_full_pre, rx_ne_pre, popped;
      logic [2:0] sel;
      bus.addr_in   = a;
      bus.r_nw_in   = rnw;
      bus.data_in   = d;
      uart_rx_valid = rxv;
      uart_rx_data  = rxd;
      uart_tx_ready = txr;
      sel         = a[2:0];
      tx_full_pre = (tx_q.size() == 16);
      rx_full_pre = (rx_q.size() == 16);
      rx_ne_pre   = (rx_q.size() != 0);
      exp_known   = 1;
      exp_dout    = 8'h00;
      popped      = (tx_q.size() != 0) && txr;
      if (popped) m_tx_log.push_back(tx_q.pop_front());
      if (!a[17]) begin
         if (rnw) begin
            if (ram_m.exists(int'(a[16:0]))) exp_dout = ram_m[int'(a[16:0])];
            else exp_known = 0;
         end else begin
            ram_m[int'(a[16:0])] = d;
         end
      end else if (rnw) begin
         if (sel == 3'd0 && rx_ne_pre) exp_dout = rx_q.pop_front();
         else if (sel == 3'd4) exp_dout = {6'b0, tx_full_pre, rx_ne_pre};
      end else begin
         if (sel == 3'd0) begin
            if (!tx_full_pre || popped) tx_q.push_back(d);
            else if (drop_m < 255) drop_m++;
         end else if (sel == 3'd4) begin
            halt_m = 1;
         end
      end
      if (rxv && !rx_full_pre) rx_q.push_back(rxd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic txr);
      step(32'h0, 1'b1, 8'h00, 1'b0, 8'h00, txr);
   endtask

   task automatic model_reset();
      tx_q.delete();
      rx_q.delete();
      drop_m   = 0;
      halt_m   = 0;
      exp_dout = 8'h00;
      exp_known = 1;
   endtask

   task automatic test_reset();
      bus.addr_in = 32'h0;
      bus.r_nw_in = 1'b1;
      bus.data_in = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
      vectors++; if (uart_tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %b want 0", uart_tx_valid); end
      vectors++; if (sim_halt !== 1'b0) begin miscompares++; $display("FAIL reset_halt got %b want 0", sim_halt); end
      vectors++; if (drop_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_drop got %h want 00", drop_cnt); end
      vectors++; if (bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL reset_buf_full got %b want 0", bus.io_buffer_full); end
      rst_n = 1'b1;
      model_reset();
      // Give RAM byte 0 a defined value so idle reads are checkable.
      step(32'h0, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_ram();
      step(32'h0000_0100, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0);
      step(32'h0000_0100, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      vectors++; if (bus.data_out !== 8'h12) begin miscompares++; $display("FAIL ram_rd_100 got %h want 12", bus.data_out); end
      step(32'h0001_FFFF, 1'b0, 8'hAB, 1'b0, 8'h00, 1'b0);
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL ram_wr_zero got %h want 00", bus.data_out); end
      step(32'h0001_FFFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      vectors++; if (bus.data_out !== 8'hAB) begin miscompares++; $display("FAIL ram_rd_1ffff got %h want ab", bus.data_out); end
      for (int i = 0; i < 60; i++) begin
         logic [16:0] idx;
         idx = 17'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 17'h1FFF8 : 17'h0);
         step({15'b0, idx}, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00, 1'b0);
         if (exp_known) begin
            vectors++;
            if (bus.data_out !== exp_dout) begin miscompares++; $display("FAIL ram_rand idx=%h got %h want %h", idx, bus.data_out, exp_dout); end
         end
      end
   endtask

   task automatic test_tx();
      dut_tx_log.delete();
      m_tx_log.delete();
      step(32'h0003_0000, 1'b0, 8'h48, 1'b0, 8'h00, 1'b1);
      vectors++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h48) begin miscompares++; $display("FAIL tx_head_H got v=%b d=%h want v=1 d=48", uart_tx_valid, uart_tx_data); end
      step(32'h0003_0000, 1'b0, 8'h69, 1'b0, 8'h00, 1'b1);
      vectors++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h69) begin miscompares++; $display("FAIL tx_head_i got v=%b d=%h want v=1 d=69", uart_tx_valid, uart_tx_data); end
      repeat (3) idle(1'b1);
      step(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL tx_status got %h want 00", bus.data_out); end
      vectors++; if (dut_tx_log.size() != 2) begin miscompares++; $display("FAIL tx_count got %0d want 2", dut_tx_log.size()); end
      else begin
         vectors++; if (dut_tx_log[0] != 8'h48 || dut_tx_log[1] != 8'h69) begin miscompares++; $display("FAIL tx_order got %h %h want 48 69", dut_tx_log[0], dut_tx_log[1]); end
      end
   endtask

   task automatic test_tx_full();
      dut_tx_log.delete();
      m_tx_log.delete();
      for (int i = 0; i < 18; i++) begin
         step(32'h0003_0000, 1'b0, 8'hA0 + 8'(i), 1'b0, 8'h00, 1'b0);
         vectors++;
         if (bus.io_buffer_full !== (i >= 13)) begin miscompares++; $display("FAIL tx_buf_full after %0d writes got %b want %b", i + 1, bus.io_buffer_full, (i >= 13)); end
      end
      vectors++; if (drop_cnt !== 8'd2) begin miscompares++; $display("FAIL tx_drop2 got %0d want 2", drop_cnt); end
      step(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      vectors++; if (bus.data_out !== 8'h02) begin miscompares++; $display("FAIL tx_full_status got %h want 02", bus.data_out); end
      for (int i = 0; i < 260; i++) step(32'h0003_0000, 1'b0, 8'h55, 1'b0, 8'h00, 1'b0);
      vectors++; if (drop_cnt !== 8'hFF) begin miscompares++; $display("FAIL tx_drop_sat got %0d want 255", drop_cnt); end
      repeat (20) idle(1'b1);
      vectors++; if (uart_tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_drained got v=%b want 0", uart_tx_valid); end
      vectors++; if (dut_tx_log.size() != 16) begin miscompares++; $display("FAIL tx_full_count got %0d want 16", dut_tx_log.size()); end
      for (int i = 0; i < 16 && i < dut_tx_log.size(); i++) begin
         vectors++;
         if (dut_tx_log[i] != 8'hA0 + 8'(i)) begin miscompares++; $display("FAIL tx_full_order[%0d] got %h want %h", i, dut_tx_log[i], 8'hA0 + 8'(i)); end
      end
   endtask

   task automatic test_rx();
      step(32'h0, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b1);
      step(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'h01) begin miscompares++; $display("FAIL rx_status got %h want 01", bus.data_out); end
      step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'h5A) begin miscompares++; $display("FAIL rx_pop got %h want 5a", bus.data_out); end
      step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL rx_empty got %h want 00", bus.data_out); end
      // Push and pop together on an empty FIFO: read sees 00, byte is kept
      step(32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'hC3, 1'b1);
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL rx_pushpop_empty got %h want 00", bus.data_out); end
      step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'hC3) begin miscompares++; $display("FAIL rx_pushpop_kept got %h want c3", bus.data_out); end
      // Overfill: the 17th byte is lost
      for (int i = 0; i < 17; i++) step(32'h0, 1'b1, 8'h00, 1'b1, 8'h10 + 8'(i), 1'b1);
      for (int i = 0; i < 17; i++) begin
         step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
         vectors++;
         if (bus.data_out !== ((i < 16) ? 8'h10 + 8'(i) : 8'h00)) begin miscompares++; $display("FAIL rx_fill[%0d] got %h want %h", i, bus.data_out, (i < 16) ? 8'h10 + 8'(i) : 8'h00); end
      end
   endtask

   task automatic test_halt();
      vectors++; if (sim_halt !== 1'b0) begin miscompares++; $display("FAIL halt_pre got %b want 0", sim_halt); end
      step(32'h0003_0004, 1'b0, 8'h77, 1'b0, 8'h00, 1'b1);
      vectors++; if (sim_halt !== 1'b1) begin miscompares++; $display("FAIL halt_set got %b want 1", sim_halt); end
      repeat (3) idle(1'b1);
      vectors++; if (sim_halt !== 1'b1) begin miscompares++; $display("FAIL halt_sticky got %b want 1", sim_halt); end
   endtask

   task automatic test_random();
      dut_tx_log.delete();
      m_tx_log.delete();
      for (int i = 0; i < 600; i++) begin
         int          r;
         logic [31:0] a;
         logic        rnw, txr;
         logic [2:0]  sel;
         r   = $urandom_range(0, 9);
         rnw = 1'($urandom_range(0, 1));
         txr = ((i % 64) < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (r < 4) begin
            a = {15'b0, 17'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 17'h1FFF8 : 17'h0)};
         end else begin
            if (r < 8) sel = 3'd0;
            else if (r == 8) begin sel = 3'd4; rnw = ($urandom_range(0, 7) != 0); end
            else sel = 3'($urandom_range(0, 7));
            a = 32'h0002_0000 | ($urandom & 32'h0001_FFF8) | {29'b0, sel};
         end
         step(a, rnw, 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), txr);
         if (exp_known) begin
            vectors++;
            if (bus.data_out !== exp_dout) begin miscompares++; $display("FAIL rnd_dout cyc=%0d a=%h got %h want %h", i, a, bus.data_out, exp_dout); end
         end
         vectors++;
         if (bus.io_buffer_full !== (tx_q.size() >= 14)) begin miscompares++; $display("FAIL rnd_buf_full cyc=%0d got %b want %b", i, bus.io_buffer_full, (tx_q.size() >= 14)); end
         vectors++;
         if (uart_tx_valid !== (tx_q.size() != 0)) begin miscompares++; $display("FAIL rnd_tx_valid cyc=%0d got %b want %b", i, uart_tx_valid, (tx_q.size() != 0)); end
         if (tx_q.size() != 0) begin
            vectors++;
            if (uart_tx_data !== tx_q[0]) begin miscompares++; $display("FAIL rnd_tx_head cyc=%0d got %h want %h", i, uart_tx_data, tx_q[0]); end
         end
         vectors++;
         if (drop_cnt !== 8'(drop_m) || sim_halt !== halt_m) begin miscompares++; $display("FAIL rnd_flags cyc=%0d got drop=%0d halt=%b want drop=%0d halt=%b", i, drop_cnt, sim_halt, drop_m, halt_m); end
      end
      vectors++;
      if (dut_tx_log.size() != m_tx_log.size()) begin miscompares++; $display("FAIL rnd_tx_log_len got %0d want %0d", dut_tx_log.size(), m_tx_log.size()); end
      for (int i = 0; i < dut_tx_log.size() && i < m_tx_log.size(); i++) begin
         vectors++;
         if (dut_tx_log[i] != m_tx_log[i]) begin miscompares++; $display("FAIL rnd_tx_log[%0d] got %h want %h", i, dut_tx_log[i], m_tx_log[i]); end
      end
   endtask

   task automatic test_reset_mid();
      repeat (20) idle(1'b1);
      step(32'h0000_0100, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step(32'h0003_0000, 1'b0, 8'h30 + 8'(i), 1'b0, 8'h00, 1'b0);
      step(32'h0000_0100, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      vectors++; if (bus.data_out !== 8'h12 || uart_tx_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got d=%h v=%b want d=12 v=1", bus.data_out, uart_tx_valid); end
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (uart_tx_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_valid got %b want 0", uart_tx_valid); end
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL rstmid_data_out got %h want 00", bus.data_out); end
      vectors++; if (sim_halt !== 1'b0 || drop_cnt !== 8'h00) begin miscompares++; $display("FAIL rstmid_flags got halt=%b drop=%0d want 0 0", sim_halt, drop_cnt); end
      #1 rst_n = 1'b1;
      model_reset();
      step(32'h0000_0100, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      vectors++; if (bus.data_out !== 8'h12) begin miscompares++; $display("FAIL rstmid_ram_kept got %h want 12", bus.data_out); end
      vectors++; if (uart_tx_valid !== 1'b0 || bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_lost got v=%b full=%b want 0 0", uart_tx_valid, bus.io_buffer_full); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_tx();
      test_tx_full();
      test_rx();
      test_halt();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
